icache_refill_mem: RTL



---
 rtl/icache_refill_mem.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/icache_refill_mem.sv
// icache_refill_mem: memory-side responder for instruction-cache line refills.
// Accepts one line request at a time, waits READ_LATENCY cycles, then streams
// LINE_BEATS consecutive words from the backing array using valid/ready with a
// last flag. A preload port fills the array while the responder is idle.
module icache_refill_mem #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int LINE_BEATS   = 4,
    parameter int MEM_DEPTH    = 1024,
    parameter int READ_LATENCY = 3
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  resp_last,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_drop,
    output logic                  busy
);

    localparam int WORD_BYTES = DATA_WIDTH / 8;
    localparam int WB_BITS    = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 0;
    localparam int BEAT_BITS  = $clog2(LINE_BEATS);
    localparam int MEM_AW     = $clog2(MEM_DEPTH);

    // WAIT is entered with the counter at READ_LATENCY-1 and leaves when it hits 0.
    localparam logic [3:0]           LAT_INIT    = (READ_LATENCY > 0) ? 4'(READ_LATENCY - 1) : 4'd0;
    localparam logic [BEAT_BITS-1:0] PENULT_BEAT = BEAT_BITS'(LINE_BEATS - 2);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_BURST = 2'd2
    } state_t;

    state_t                 state_reg;
    logic [DATA_WIDTH-1:0]  mem [MEM_DEPTH];
    logic [MEM_AW-1:0]      base_reg;
    logic [BEAT_BITS-1:0]   beat_reg;
    logic [3:0]             lat_cnt_reg;
    logic                   req_ready_reg;
    logic                   resp_valid_reg;
    logic                   resp_last_reg;
    logic [DATA_WIDTH-1:0]  resp_data_reg;
    logic                   wr_drop_reg;
    logic                   busy_reg;

    logic [ADDR_WIDTH-1:0]  req_word;
    logic [ADDR_WIDTH-1:0]  wr_word;
    logic [MEM_AW-1:0]      req_base;
    logic [MEM_AW-1:0]      wr_idx;
    logic [MEM_AW-1:0]      rd_idx;
    logic [DATA_WIDTH-1:0]  rd_word;
    logic                   accept;
    logic                   wr_take;
    logic                   beat_hs;
    logic                   unused_addr_bits;

    // Byte addresses become word indices; bits above the array range are dropped.
    assign req_word = req_addr >> WB_BITS;
    assign wr_word  = wr_addr >> WB_BITS;
    assign req_base = {req_word[MEM_AW-1:BEAT_BITS], {BEAT_BITS{1'b0}}};
    assign wr_idx   = wr_word[MEM_AW-1:0];
    assign unused_addr_bits = ^{req_word, wr_word};

    // req_ready_reg is only ever high in IDLE, so it alone qualifies an accept.
    assign accept  = req_valid && req_ready_reg;
    assign wr_take = wr_en && (state_reg == ST_IDLE);
    assign beat_hs = resp_valid_reg && resp_ready;

    // Read address for the next word to be loaded into the response register.
    always_comb begin
        rd_idx = base_reg;
        case (state_reg)
            ST_IDLE:  rd_idx = req_base;
            ST_BURST: rd_idx = base_reg + MEM_AW'(beat_reg) + MEM_AW'(1);
            default:  rd_idx = base_reg;
        endcase
    end

    // A preload landing on the same edge as a zero-latency accept must be seen
    // by the first beat, so the write data is forwarded around the array.
    assign rd_word = (wr_take && (wr_idx == rd_idx)) ? wr_data : mem[rd_idx];

    // Preload port: writes land only while idle; the array is never reset.
    always_ff @(posedge clock) begin
        if (wr_take) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Request/response state machine with all outputs registered.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= ST_IDLE;
            base_reg       <= '0;
            beat_reg       <= '0;
            lat_cnt_reg    <= '0;
            req_ready_reg  <= 1'b0;
            resp_valid_reg <= 1'b0;
            resp_last_reg  <= 1'b0;
            resp_data_reg  <= '0;
            wr_drop_reg    <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            wr_drop_reg <= wr_en && (state_reg != ST_IDLE);
            case (state_reg)
                ST_IDLE: begin
                    req_ready_reg <= 1'b1;
                    if (accept) begin
                        base_reg      <= req_base;
                        beat_reg      <= '0;
                        req_ready_reg <= 1'b0;
                        busy_reg      <= 1'b1;
                        if (READ_LATENCY == 0) begin
                            state_reg      <= ST_BURST;
                            resp_valid_reg <= 1'b1;
                            resp_last_reg  <= 1'b0;
                            resp_data_reg  <= rd_word;
                        end else begin
                            state_reg   <= ST_WAIT;
                            lat_cnt_reg <= LAT_INIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (lat_cnt_reg == 4'd0) begin
                        state_reg      <= ST_BURST;
                        resp_valid_reg <= 1'b1;
                        resp_last_reg  <= 1'b0;
                        resp_data_reg  <= rd_word;
                    end else begin
                        lat_cnt_reg <= lat_cnt_reg - 4'd1;
                    end
                end
                ST_BURST: begin
                    // Data and last are only updated on a handshake, which
                    // keeps them stable under backpressure.
                    if (beat_hs) begin
                        if (resp_last_reg) begin
                            state_reg      <= ST_IDLE;
                            resp_valid_reg <= 1'b0;
                            resp_last_reg  <= 1'b0;
                            beat_reg       <= '0;
                            busy_reg       <= 1'b0;
                            req_ready_reg  <= 1'b1;
                        end else begin
                            beat_reg      <= beat_reg + BEAT_BITS'(1);
                            resp_data_reg <= rd_word;
                            resp_last_reg <= (beat_reg == PENULT_BEAT);
                        end
                    end
                end
                default: begin
                    state_reg      <= ST_IDLE;
                    resp_valid_reg <= 1'b0;
                    resp_last_reg  <= 1'b0;
                    busy_reg       <= 1'b0;
                    req_ready_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_reg;
    assign resp_valid = resp_valid_reg;
    assign resp_data  = resp_data_reg;
    assign resp_last  = resp_last_reg;
    assign wr_drop    = wr_drop_reg;
    assign busy       = busy_reg;

endmodule
